progmem_loadable: RTL and testbench



---
 rtl/progmem_pkg.sv | 17 +
 rtl/progmem_load_fsm.sv | 95 +++++++++
 rtl/progmem_loadable.sv | 59 +++++
 tb/tb_progmem_loadable.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/progmem_pkg.sv
// Shared types and constants for the loadable TD4 program memory.
package progmem_pkg;

    localparam int ADDR_W_DEFAULT = 4;
    localparam int DATA_W_DEFAULT = 8;

    localparam logic [DATA_W_DEFAULT-1:0] NOP_WORD = '0;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/progmem_load_fsm.sv
// Streaming loader control: write pointer, handshake, CPU hold; checksum path under PROGMEM_CHECKSUM_EN.
// state | meaning
// EMPTY | nothing loaded, CPU held      LOAD  | accepting data words
// CHECK | awaiting checksum word        RUN   | CPU released
// ERROR | checksum mismatch, CPU held
module progmem_load_fsm
    import progmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
`ifdef PROGMEM_CHECKSUM_EN
    ,
    parameter int DATA_W = DATA_W_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
`ifdef PROGMEM_CHECKSUM_EN
    input  logic [DATA_W-1:0] in_data,
`endif
    output logic              in_ready,
    output logic              cpu_run,
    output logic              load_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic              accept;
`ifdef PROGMEM_CHECKSUM_EN
    logic [DATA_W-1:0] acc, acc_nx;
`endif

    // load_start always wins over a word offered in the same cycle
    assign accept  = in_valid & in_ready & ~load_start;
    assign wr_addr = ptr;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        wr_en    = 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
        acc_nx   = acc;
`endif
        if (load_start) begin
            state_nx = ST_LOAD;
            ptr_nx   = '0;
`ifdef PROGMEM_CHECKSUM_EN
            acc_nx   = '0;
`endif
        end else if (accept) begin
            case (state)
                ST_LOAD: begin
                    wr_en  = 1'b1;
                    ptr_nx = ptr + 1'b1;
`ifdef PROGMEM_CHECKSUM_EN
                    acc_nx = acc + in_data;
                    if (&ptr) state_nx = ST_CHECK;
`else
                    if (&ptr) state_nx = ST_RUN;
`endif
                end
`ifdef PROGMEM_CHECKSUM_EN
                ST_CHECK: state_nx = (in_data == acc) ? ST_RUN : ST_ERROR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            ptr      <= '0;
            in_ready <= 1'b0;
            cpu_run  <= 1'b0;
            load_err <= 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
            acc      <= '0;
`endif
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            in_ready <= (state_nx == ST_LOAD) || (state_nx == ST_CHECK);
            cpu_run  <= (state_nx == ST_RUN);
            load_err <= (state_nx == ST_ERROR);
`ifdef PROGMEM_CHECKSUM_EN
            acc      <= acc_nx;
`endif
        end
    end

endmodule

// File: rtl/progmem_loadable.sv
// Writable TD4 program memory: combinational fetch port plus host streaming loader.
// Optional checksum word after the image is enabled by PROGMEM_CHECKSUM_EN.
module progmem_loadable
    import progmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cpu_run,
    output logic              load_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    progmem_load_fsm #(
        .ADDR_W(ADDR_W)
`ifdef PROGMEM_CHECKSUM_EN
        ,
        .DATA_W(DATA_W)
`endif
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_start(load_start),
        .in_valid  (in_valid),
`ifdef PROGMEM_CHECKSUM_EN
        .in_data   (in_data),
`endif
        .in_ready  (in_ready),
        .cpu_run   (cpu_run),
        .load_err  (load_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(NOP_WORD);
        end else if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    // no write bypass: a word appears on D only after its write edge
    assign D = mem[A];

endmodule

// File: tb/tb_progmem_loadable.sv
// Scoreboard bench for progmem_loadable against a word-count reference model.
module tb_progmem_loadable;

    localparam int DEPTH = 16;
`ifdef PROGMEM_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int P_EMPTY = 0, P_LOAD = 1, P_CHECK = 2, P_RUN = 3, P_ERR = 4;
    localparam int K_MEM = 0, K_READY = 1, K_RUN = 2, K_ERR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A;
    logic [7:0] D;
    logic       load_start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       cpu_run;
    logic       load_err;

    always #5 clk = ~clk;

    progmem_loadable dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .D         (D),
        .load_start(load_start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cpu_run   (cpu_run),
        .load_err  (load_err)
    );

    typedef struct {
        int         kind;
        int         addr;
        logic [7:0] exp;
    } item_t;

    item_t q[$];
    int    pending = 0;
    int    checks  = 0;
    int    errors  = 0;
    event  do_check;

    // reference model: what the host has delivered, counted in words
    logic [7:0] ref_mem [DEPTH];
    int         m_phase;
    int         m_cnt;
    logic [7:0] m_sum;

    task automatic push(input int kind, input int addr, input logic [7:0] exp);
        q.push_back(item_t'{kind, addr, exp});
        pending++;
    endtask

    initial begin
        item_t      it;
        logic [7:0] act;
        string      nm;
        A = '0;
        forever begin
            @(do_check);
            #1;
            while (q.size() > 0) begin
                it = q[0];
                act = 8'h00;
                nm = "";
                case (it.kind)
                    K_MEM: begin
                        A = 4'(it.addr);
                        #1;
                        act = D;
                        nm = $sformatf("D@%0d", it.addr);
                    end
                    K_READY: begin act = {7'b0, in_ready}; nm = "in_ready"; end
                    K_RUN:   begin act = {7'b0, cpu_run};  nm = "cpu_run";  end
                    default: begin act = {7'b0, load_err}; nm = "load_err"; end
                endcase
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, it.exp);
                end
                void'(q.pop_front());
                pending--;
            end
        end
    end

    task automatic model_reset();
        m_phase = P_EMPTY;
        m_cnt   = 0;
        m_sum   = 8'h00;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load_start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // one clock of stimulus; called at a falling edge, returns at the next one
    task automatic cycle(input logic ls, input logic v, input logic [7:0] d);
        int ra;
        load_start = ls;
        in_valid   = v;
        in_data    = d;
        push(K_READY, 0, {7'b0, (m_phase == P_LOAD) || (m_phase == P_CHECK)});
        push(K_RUN,   0, {7'b0, m_phase == P_RUN});
        push(K_ERR,   0, {7'b0, m_phase == P_ERR});
        ra = $urandom_range(0, DEPTH - 1);
        push(K_MEM, ra, ref_mem[ra]);
        ->do_check;
        wait (pending == 0);
        if (ls) begin
            m_phase = P_LOAD;
            m_cnt   = 0;
            m_sum   = 8'h00;
        end else if (v && m_phase == P_LOAD) begin
            ref_mem[m_cnt] = d;
            m_sum = m_sum + d;
            m_cnt++;
            if (m_cnt == DEPTH) m_phase = CSUM ? P_CHECK : P_RUN;
        end else if (v && m_phase == P_CHECK) begin
            m_phase = (d == m_sum) ? P_RUN : P_ERR;
        end
        @(negedge clk);
    endtask

    task automatic check_mem();
        load_start = 1'b0;
        in_valid   = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(K_MEM, i, ref_mem[i]);
        ->do_check;
        wait (pending == 0);
        @(negedge clk);
    endtask

    // pat: 0 = 8'hB0+i, 1 = i, 2 = random; vmode: 0 = always, 1 = toggling, 2 = random
    task automatic finish_load(input int pat, input int vmode, input logic [7:0] cs_delta);
        int         guard;
        logic       v;
        logic [7:0] d;
        guard = 0;
        while ((m_phase == P_LOAD || m_phase == P_CHECK) && guard < 200) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            if (m_phase == P_CHECK)  d = m_sum + cs_delta;
            else if (pat == 0)       d = 8'hB0 + 8'(m_cnt);
            else if (pat == 1)       d = 8'(m_cnt);
            else                     d = 8'($urandom);
            if (!v) d = in_data;
            cycle(1'b0, v, d);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL load_timeout: got %0d cycles expected under 200", guard);
        end
    endtask

    task automatic run_load(input int pat, input int vmode, input logic [7:0] cs_delta);
        cycle(1'b1, 1'b0, 8'h00);
        finish_load(pat, vmode, cs_delta);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        load_start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        model_reset();
        @(negedge clk);
        do_reset();

        check_mem();
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom));

        run_load(0, 0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check_mem();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'($urandom));

        run_load(2, 1, 8'h00);
        check_mem();
        run_load(2, 2, 8'h00);
        check_mem();

        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'($urandom));
        cycle(1'b1, 1'b1, 8'hEE);
        cycle(1'b0, 1'b1, 8'h11);
        check_mem();
        finish_load(2, 0, 8'h00);
        check_mem();

        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'($urandom));
        do_reset();
        check_mem();
        cycle(1'b0, 1'b0, 8'h00);
        run_load(0, 0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check_mem();

`ifdef PROGMEM_CHECKSUM_EN
        run_load(1, 0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        run_load(1, 0, 8'h01);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom));
        cycle(1'b1, 1'b0, 8'h00);
        finish_load(2, 2, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check_mem();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
